// File: rtl/board_link_rx.sv
// board_link_rx: synchronize, glitch-filter and qualify the peer board's link signals.
// Optional stuck-throw timeout enabled by defining BOARD_LINK_TIMEOUT_EN.
module board_link_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int POWER_STABLE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 600_000_000
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       in_player1_ready,
  input  logic       in_player2_ready,
  input  logic [3:0] in_power,
  input  logic       in_throw_flag,
  output logic       player1_ready_q,
  output logic       player2_ready_q,
  output logic [3:0] power_q,
  output logic       power_valid,
  output logic       throw_flag_q,
  output logic       throw_start,
  output logic       throw_end,
  output logic       link_error
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int PW = $clog2(POWER_STABLE_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_CYCLES - 1);
  localparam logic [PW-1:0] PMAX = PW'(POWER_STABLE_CYCLES);

`ifdef BOARD_LINK_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, FLIGHT, FAULT} state_t;
`else
  typedef enum logic {IDLE, FLIGHT} state_t;
`endif

  logic [6:0] sy [SYNC_STAGES];
  logic [6:0] s;
  logic [3:0] sp;
  logic [2:0] flt, flt_nx;
  logic [FW-1:0] fcnt [3];
  logic [FW-1:0] fcnt_nx [3];
  logic [PW-1:0] pcnt, pcnt_nx;
  logic load, start_nx, end_nx, fault;
  state_t state, state_nx;

  assign s = sy[SYNC_STAGES-1];
  assign sp = sy[SYNC_STAGES-2][3:0];
  assign player1_ready_q = flt[0];
  assign player2_ready_q = flt[1];
  assign throw_flag_q = state == FLIGHT;
  assign power_valid = pcnt == PMAX && s[3:0] == power_q;

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sy[i] <= '0;
    end else begin
      sy[0] <= {in_throw_flag, in_player2_ready, in_player1_ready, in_power};
      for (int i = 1; i < SYNC_STAGES; i++) sy[i] <= sy[i-1];
    end
  end

  // bit 0/1/2 of the filter = player1 ready, player2 ready, throw flag
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      flt_nx[i] = (s[4+i] != flt[i] && fcnt[i] == FMAX) ? s[4+i] : flt[i];
      fcnt_nx[i] = (s[4+i] == flt[i] || fcnt[i] == FMAX) ? '0 : fcnt[i] + 1'b1;
    end
  end

  // sp is the value the bus takes next edge, so a change clears the count as it lands
  assign pcnt_nx = (sp != s[3:0]) ? '0 : (pcnt == PMAX) ? PMAX : pcnt + 1'b1;
  assign load = pcnt_nx == PMAX && s[3:0] != power_q && !throw_flag_q;

`ifdef BOARD_LINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic timeout;
  assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk60MHz) begin
    tcnt <= (rst || state != FLIGHT || state_nx != FLIGHT) ? '0 : tcnt + 1'b1;
    link_error <= rst ? 1'b0 : link_error | fault;
  end
`else
  assign link_error = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    start_nx = 1'b0;
    end_nx = 1'b0;
    fault = 1'b0;
    case (state)
      IDLE: begin
        state_nx = flt_nx[2] ? FLIGHT : IDLE;
        start_nx = flt_nx[2];
      end
      FLIGHT:
        if (!flt_nx[2]) begin
          state_nx = IDLE;
          end_nx = 1'b1;
        end
`ifdef BOARD_LINK_TIMEOUT_EN
        else if (timeout) begin
          state_nx = FAULT;
          end_nx = 1'b1;
          fault = 1'b1;
        end
      FAULT: state_nx = flt_nx[2] ? FAULT : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      flt <= '0;
      for (int i = 0; i < 3; i++) fcnt[i] <= '0;
      pcnt <= '0;
      power_q <= '0;
      state <= IDLE;
      throw_start <= 1'b0;
      throw_end <= 1'b0;
    end else begin
      flt <= flt_nx;
      for (int i = 0; i < 3; i++) fcnt[i] <= fcnt_nx[i];
      pcnt <= pcnt_nx;
      if (load) power_q <= s[3:0];
      state <= state_nx;
      throw_start <= start_nx;
      throw_end <= end_nx;
    end
  end
endmodule

// File: tb/tb_board_link_rx.sv
// tb_board_link_rx: directed checks of board_link_rx with small filter/timeout parameters.
module tb_board_link_rx;
`ifdef BOARD_LINK_TIMEOUT_EN
  localparam logic TO = 1'b1;
`else
  localparam logic TO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic p1 = 1'b1, p2 = 1'b1, tf_in = 1'b1;
  logic [3:0] pw = 4'hf;
  logic p1q, p2q, pvalid, tfq, ts, te, err;
  logic [3:0] pq;
  int total = 0, passed = 0, n_start, n_end;

  board_link_rx #(
    .SYNC_STAGES(2), .FILTER_CYCLES(4), .POWER_STABLE_CYCLES(8), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk60MHz(clk), .rst(rst), .in_player1_ready(p1), .in_player2_ready(p2),
    .in_power(pw), .in_throw_flag(tf_in), .player1_ready_q(p1q), .player2_ready_q(p2q),
    .power_q(pq), .power_valid(pvalid), .throw_flag_q(tfq), .throw_start(ts),
    .throw_end(te), .link_error(err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs", {p1q, p2q, pq, pvalid, tfq, ts, te, err}, 0);
    end
    rst = 1'b0;
    tick(5);
    chk("p1_before_6", p1q, 0);
    tick();
    chk("p1_at_6", p1q, 1);
    chk("p2_at_6", p2q, 1);
    chk("start_at_6", ts, 1);
    chk("flag_at_6", tfq, 1);
    rst = 1'b1;
    tick();
    chk("midflight_reset_flag", tfq, 0);
    chk("midflight_reset_noend", te, 0);
    {p1, p2, tf_in, pw} = '0;
    tick(2);
    rst = 1'b0;
    tick(12);
    p2 = 1'b1;
    tick(3);
    p2 = 1'b0;
    tick(8);
    chk("glitch3_rejected", p2q, 0);
    p2 = 1'b1;
    tick(4);
    p2 = 1'b0;
    tick();
    chk("pulse4_before_6", p2q, 0);
    tick();
    chk("pulse4_at_6", p2q, 1);
    tick(4);
    chk("pulse4_falls", p2q, 0);
    pw = 4'd9;
    tick(9);
    chk("power_before_10", pq, 0);
    chk("valid_before_10", pvalid, 0);
    tick();
    chk("power_at_10", pq, 9);
    chk("valid_at_10", pvalid, 1);
    pw = 4'd3;
    tick(2);
    pw = 4'd9;
    chk("valid_drops", pvalid, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("power_holds_9", pq, 9);
    end
    chk("valid_still_low", pvalid, 0);
    tick();
    chk("valid_returns", pvalid, 1);
    tf_in = 1'b1;
    tick(5);
    chk("throw_start_early", ts, 0);
    tick();
    chk("throw_start", ts, 1);
    chk("throw_flag_rise", tfq, 1);
    tick();
    chk("throw_start_1cyc", ts, 0);
    pw = 4'd5;
    n_start = 0;
    n_end = 0;
    for (int i = 0; i < 43; i++) begin
      tick();
      n_start += int'(ts);
      n_end += int'(te);
    end
    chk("flight_no_pulses", n_start + n_end, 0);
    chk("power_frozen", pq, 9);
    chk("frozen_invalid", pvalid, 0);
    tf_in = 1'b0;
    tick(5);
    chk("flag_before_fall", tfq, 1);
    chk("end_early", te, 0);
    tick();
    chk("flag_fall", tfq, 0);
    chk("throw_end", te, 1);
    chk("power_frozen_at_end", pq, 9);
    tick();
    chk("throw_end_1cyc", te, 0);
    chk("power_after_throw", pq, 5);
    chk("valid_after_throw", pvalid, 1);
    tf_in = 1'b1;
    tick(6);
    chk("to_start", ts, 1);
    tick(99);
    chk("to_flag_99", tfq, 1);
    tick();
    chk("to_flag_100", tfq, !TO);
    chk("to_end", te, TO);
    chk("to_error", err, TO);
    n_start = 0;
    for (int i = 0; i < 190; i++) begin
      tick();
      n_start += int'(ts);
    end
    chk("to_no_restart", n_start, 0);
    chk("to_flag_held", tfq, !TO);
    tf_in = 1'b0;
    tick(6);
    chk("to_release_end", te, !TO);
    chk("to_release_flag", tfq, 0);
    chk("to_error_sticky", err, TO);
    tf_in = 1'b1;
    tick(6);
    chk("to_restart", ts, 1);
    chk("to_error_final", err, TO);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/board_link_rx.md
# board_link_rx

Receive-side qualifier for the board-to-board link. The peer board's inter-board signals enter this block before the game logic sees them: `in_player1_ready`, `in_player2_ready`, `in_power`, `in_throw_flag`. It synchronizes each signal into the `clk60MHz` domain, glitch-filters the single-bit lines and accepts the power bus only once it is stable. It also turns the peer throw flag into clean start/end pulses and, optionally, detects a stuck throw flag.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — synchronizer flops per input bit; minimum 2.
- `FILTER_CYCLES`, 16 — consecutive cycles a single-bit line must hold a new value before it is accepted; minimum 1.
- `POWER_STABLE_CYCLES`, 64 — consecutive cycles the synchronized power bus must be unchanged before it is accepted; minimum 1.
- `TIMEOUT_CYCLES`, 600_000_000 — maximum throw duration (10 s at 60 MHz). Used only when `BOARD_LINK_TIMEOUT_EN` is defined.

Ports:
- `clk60MHz` in 1 — system clock. This is the block's only clock.
- `rst` in 1 — synchronous reset, active-high.
- `in_player1_ready` in 1 — asynchronous, from peer board.
- `in_player2_ready` in 1 — asynchronous, from peer board.
- `in_power` in 4 — asynchronous power bus from peer board.
- `in_throw_flag` in 1 — asynchronous; high while the peer projectile is in flight.
- `player1_ready_q` out 1 — filtered ready line.
- `player2_ready_q` out 1 — filtered ready line.
- `power_q` out 4 — last accepted power value.
- `power_valid` out 1 — high while `power_q` equals the current stable synchronized bus.
- `throw_flag_q` out 1 — filtered throw flag, with timeout forcing applied.
- `throw_start` out 1 — one-cycle pulse when `throw_flag_q` rises.
- `throw_end` out 1 — one-cycle pulse when `throw_flag_q` falls.
- `link_error` out 1 — sticky stuck-flag indicator.

## Operation
- **Synchronizers:** every input bit passes through a `SYNC_STAGES` flop chain. No logic sits between the flops.
- **Bit filter:** applied to the ready lines and the throw flag. Each line has its own counter.
  - While the synchronized value equals the current output, the counter is held at 0.
  - While it differs, the counter increments. When the count reaches `FILTER_CYCLES`, the output takes the synchronized value and the counter clears.
  - A single-cycle return to the old value restarts the count from 0.
- **Power qualifier:**
  - The stability counter clears on any change of the synchronized 4-bit bus and saturates at `POWER_STABLE_CYCLES`.
  - When the counter is saturated and the bus differs from `power_q`, `power_q` loads the bus, provided `throw_flag_q` = 0.
  - While `throw_flag_q` = 1, `power_q` is frozen. Counting continues, and the load happens on the first cycle after the throw ends if the bus is still stable.
  - `power_valid` = counter saturated AND bus == `power_q`.
- **Throw FSM** (states `IDLE`, `FLIGHT`, `FAULT`):
  - `IDLE` → `FLIGHT` when the filtered flag rises. `throw_start` pulses in the same cycle that `throw_flag_q` goes to 1.
  - `FLIGHT` → `IDLE` when the filtered flag falls. `throw_end` pulses.
  - `FLIGHT` → `FAULT` on timeout (only when `BOARD_LINK_TIMEOUT_EN` is defined). `throw_flag_q` is forced to 0, `throw_end` pulses and `link_error` is set.
  - `FAULT` → `IDLE` only after the filtered flag has been seen at 0, so a flag still stuck high does not retrigger `throw_start`.
  - `throw_flag_q` = 1 only in `FLIGHT`.
- **Simultaneous events:** if the filtered flag falls in the same cycle the timeout fires, the fall wins: the FSM goes to `IDLE`, one `throw_end` pulses and `link_error` is not set.
- **Counter widths:** `$clog2(param+1)`. All counters saturate and never wrap.

## Timing
- **Reset values:** all outputs 0, FSM in `IDLE`, all counters 0, synchronizer chains 0. `link_error` clears only on `rst`.
- **Reset mid-operation:** reset during `FLIGHT` returns to `IDLE` with no `throw_end` pulse.
- **Single-bit latency:** an input change is reflected on the filtered output `SYNC_STAGES + FILTER_CYCLES` rising edges after it is first sampled.
- **Power latency:** `power_q` updates `SYNC_STAGES + POWER_STABLE_CYCLES` edges after the last bus change, when no throw is active.
- **Pulses:** `throw_start` and `throw_end` are exactly one cycle wide and never asserted together.

## Configuration
- `BOARD_LINK_TIMEOUT_EN` defined:
  - A flight counter runs in `FLIGHT` and clears on entry.
  - When it reaches `TIMEOUT_CYCLES`, the FSM takes the `FLIGHT` → `FAULT` transition.
- `BOARD_LINK_TIMEOUT_EN` undefined:
  - No counter and no `FAULT` state are implemented.
  - `link_error` is tied to 0.
  - `FLIGHT` persists as long as the filtered flag is high.

## Test plan
All scenarios use `SYNC_STAGES`=2, `FILTER_CYCLES`=4, `POWER_STABLE_CYCLES`=8, `TIMEOUT_CYCLES`=100.
- **Reset:** hold `rst` for 3 cycles with all inputs = 1 → all outputs 0 throughout. `player1_ready_q` = 1 exactly 6 edges after `rst` falls.
- **Glitch rejection:** `in_player2_ready` pulses high for 3 cycles → `player2_ready_q` stays 0. A pulse of 4 or more cycles → output rises 6 edges after the rise.
- **Power:** drive `in_power` = 9 and hold → `power_q` = 9 and `power_valid` = 1 after 10 edges. Toggle to 3 for 2 cycles, then back to 9 → `power_valid` drops, then returns after 8 stable cycles, and `power_q` never shows 3.
- **Throw:** hold `in_throw_flag` high for 50 cycles → one `throw_start` at edge 6 after the rise and one `throw_end` 6 edges after the fall.
- **Power freeze:** change `in_power` to 5 during a throw → `power_q` is unchanged until the cycle after `throw_flag_q` falls, then becomes 5.
- **Timeout (macro on):** hold `in_throw_flag` high for 300 cycles → `throw_end` fires after 100 cycles in `FLIGHT`, `link_error` = 1 and `throw_flag_q` = 0. No second `throw_start` occurs until the flag drops and rises again. Macro off: `link_error` stays 0 and `throw_flag_q` stays 1.
